// File: rtl/input_cond_pkg.sv
// Shared types and defaults for the push-button input conditioner.
package input_cond_pkg;

    localparam int unsigned DATA_W_DEFAULT          = 7;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } debounce_state_t;

endpackage

// File: rtl/debounce_fsm.sv
// Per-button debouncer: requests one press after DEBOUNCE_CYCLES+1 stable-high
// samples, then re-arms only after an equally long stable-low period.
module debounce_fsm
    import input_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset_n,
    input  logic level_in,
    output logic press_req
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    debounce_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_req <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_req <= press_d;
        end
    end

    // Counter saturates at CNT_MAX; the transition fires on the sample after it gets there.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (level_in) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!level_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    state_d = HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            HELD: begin
                if (!level_in) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (level_in) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/input_conditioner.sv
// Debounces Next/Done buttons into single-cycle strobes and captures the data
// switches on each accepted Next press.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int unsigned DATA_W          = DATA_W_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              next_sync,
    input  logic              done_sync,
    input  logic [DATA_W-1:0] data_sync,
    output logic              next_pulse,
    output logic              done_pulse,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid
);

    logic next_req;
    logic done_req;

    debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_next_db (
        .clock     (clock),
        .reset_n   (reset_n),
        .level_in  (next_sync),
        .press_req (next_req)
    );

    debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_done_db (
        .clock     (clock),
        .reset_n   (reset_n),
        .level_in  (done_sync),
        .press_req (done_req)
    );

    // Done wins a same-cycle collision; the Next request is dropped outright.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            next_pulse <= 1'b0;
            done_pulse <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            next_pulse <= next_req & ~done_req;
            done_pulse <= done_req;
            if (done_req) begin
                data_valid <= 1'b0;
            end else if (next_req) begin
                data_valid <= 1'b1;
                data_out   <= data_sync;
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a run-length reference model.
module tb_input_conditioner;

    localparam int unsigned D = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       next_sync = 1'b0;
    logic       done_sync = 1'b0;
    logic [6:0] data_sync = 7'h00;
    logic       next_pulse;
    logic       done_pulse;
    logic [6:0] data_out;
    logic       data_valid;

    int errors = 0;
    int checks = 0;
    int n_next = 0;
    int n_done = 0;

    input_conditioner #(
        .DATA_W          (7),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .next_sync  (next_sync),
        .done_sync  (done_sync),
        .data_sync  (data_sync),
        .next_pulse (next_pulse),
        .done_pulse (done_pulse),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Model: a press is accepted once D+1 consecutive high samples are seen while
    // armed; re-arming needs D+1 consecutive low samples. Strobe lands one edge later.
    int         run_hi [2];
    int         run_lo [2];
    bit         armed  [2];
    bit         pend   [2];
    logic       exp_next = 1'b0;
    logic       exp_done = 1'b0;
    logic       exp_valid = 1'b0;
    logic [6:0] exp_data = 7'h00;

    initial begin
        for (int b = 0; b < 2; b++) begin
            run_hi[b] = 0; run_lo[b] = 0; armed[b] = 1'b1; pend[b] = 1'b0;
        end
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                for (int b = 0; b < 2; b++) begin
                    run_hi[b] = 0; run_lo[b] = 0; armed[b] = 1'b1; pend[b] = 1'b0;
                end
                exp_next = 1'b0; exp_done = 1'b0; exp_valid = 1'b0; exp_data = 7'h00;
            end else begin
                exp_next = pend[0] && !pend[1];
                exp_done = pend[1];
                if (pend[1]) exp_valid = 1'b0;
                else if (pend[0]) begin
                    exp_valid = 1'b1;
                    exp_data  = data_sync;
                end
                for (int b = 0; b < 2; b++) begin
                    logic lvl;
                    lvl = (b == 0) ? next_sync : done_sync;
                    pend[b] = 1'b0;
                    if (lvl) begin
                        run_hi[b]++;
                        run_lo[b] = 0;
                        if (armed[b] && run_hi[b] == int'(D) + 1) begin
                            pend[b]  = 1'b1;
                            armed[b] = 1'b0;
                        end
                    end else begin
                        run_lo[b]++;
                        run_hi[b] = 0;
                        if (!armed[b] && run_lo[b] == int'(D) + 1) armed[b] = 1'b1;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, plus pulse counting.
    initial begin
        forever begin
            @(negedge clock);
            chk("cyc_next_pulse", 32'(next_pulse), 32'(exp_next));
            chk("cyc_done_pulse", 32'(done_pulse), 32'(exp_done));
            chk("cyc_data_valid", 32'(data_valid), 32'(exp_valid));
            chk("cyc_data_out",   32'(data_out),   32'(exp_data));
            if (next_pulse) n_next++;
            if (done_pulse) n_done++;
        end
    end

    initial begin
        int cn;
        int cd;

        // Initial reset
        #1 reset_n = 1'b0;
        tick(3);
        chk("rst_next_pulse", 32'(next_pulse), 32'd0);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        reset_n = 1'b1;
        tick(3);

        // Clean press
        data_sync = 7'h2A; next_sync = 1'b1; cn = n_next;
        tick(5);
        chk("clean_early", 32'(next_pulse), 32'd0);
        tick(1);
        chk("clean_pulse", 32'(next_pulse), 32'd1);
        chk("clean_data",  32'(data_out),   32'h2A);
        chk("clean_valid", 32'(data_valid), 32'd1);
        tick(1);
        chk("clean_width", 32'(next_pulse), 32'd0);
        tick(13);
        chk("clean_count", 32'(n_next - cn), 32'd1);
        next_sync = 1'b0;
        tick(8);

        // Reset in the middle of a press
        data_sync = 7'h11; next_sync = 1'b1;
        tick(2);
        #2 reset_n = 1'b0; next_sync = 1'b0;
        #1;
        chk("midrst_valid", 32'(data_valid), 32'd0);
        chk("midrst_data",  32'(data_out),   32'd0);
        chk("midrst_pulse", 32'(next_pulse), 32'd0);
        tick(1);
        reset_n = 1'b1; cn = n_next;
        tick(10);
        chk("midrst_nopulse", 32'(n_next - cn), 32'd0);

        // Bouncing press
        data_sync = 7'h33; cn = n_next;
        repeat (5) begin
            next_sync = 1'b1; tick(3);
            next_sync = 1'b0; tick(1);
        end
        next_sync = 1'b1;
        tick(5);
        chk("bounce_none", 32'(n_next - cn), 32'd0);
        tick(1);
        chk("bounce_pulse", 32'(next_pulse), 32'd1);
        chk("bounce_data",  32'(data_out),   32'h33);
        tick(10);
        chk("bounce_count", 32'(n_next - cn), 32'd1);

        // Release glitch while held, then a genuine re-press
        next_sync = 1'b0; tick(2);
        next_sync = 1'b1; tick(10);
        chk("glitch_none", 32'(n_next - cn), 32'd1);
        data_sync = 7'h15;
        next_sync = 1'b0; tick(6);
        next_sync = 1'b1;
        tick(5);
        chk("repress_early", 32'(next_pulse), 32'd0);
        tick(1);
        chk("repress_pulse", 32'(next_pulse), 32'd1);
        chk("repress_data",  32'(data_out),   32'h15);
        tick(5);
        next_sync = 1'b0; tick(8);

        // Simultaneous Next and Done
        data_sync = 7'h44; cn = n_next; cd = n_done;
        next_sync = 1'b1; done_sync = 1'b1;
        tick(6);
        chk("sim_done",  32'(done_pulse), 32'd1);
        chk("sim_next",  32'(next_pulse), 32'd0);
        chk("sim_data",  32'(data_out),   32'h15);
        chk("sim_valid", 32'(data_valid), 32'd0);
        tick(10);
        chk("sim_next_count", 32'(n_next - cn), 32'd0);
        chk("sim_done_count", 32'(n_done - cd), 32'd1);
        next_sync = 1'b0; done_sync = 1'b0; tick(8);

        // Done clears valid, data held
        data_sync = 7'h7F; next_sync = 1'b1;
        tick(6);
        chk("cap_pulse", 32'(next_pulse), 32'd1);
        chk("cap_data",  32'(data_out),   32'h7F);
        tick(2);
        next_sync = 1'b0; tick(8);
        data_sync = 7'h00; done_sync = 1'b1;
        tick(5);
        chk("done_pre_valid", 32'(data_valid), 32'd1);
        tick(1);
        chk("done_pulse", 32'(done_pulse), 32'd1);
        chk("done_valid", 32'(data_valid), 32'd0);
        chk("done_data",  32'(data_out),   32'h7F);
        tick(3);
        chk("done_hold_valid", 32'(data_valid), 32'd0);
        chk("done_hold_data",  32'(data_out),   32'h7F);
        done_sync = 1'b0; tick(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
